// File: rtl/score_ascii_encoder_pkg.sv
// Shared definitions for the score-to-ASCII path: character codes, FSM encoding,
// and the packed-score field layout that the score character ROM also decodes.
package score_ascii_encoder_pkg;

    localparam logic [6:0] ASCII_ZERO  = 7'h30;
    localparam logic [6:0] ASCII_SPACE = 7'h20;

    localparam int SCORE_WORD_W = 14;
    localparam int TENS_MSB     = 13;
    localparam int TENS_LSB     = 7;
    localparam int UNITS_MSB    = 6;
    localparam int UNITS_LSB    = 0;

    // Two BCD digits only: the input is clamped below 100 before conversion.
    localparam int BCD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic [SCORE_WORD_W-1:0] pack_score(
        input logic [3:0] tens,
        input logic [3:0] units,
        input logic       blank_leading
    );
        logic [6:0] tens_char;
        logic [6:0] units_char;
        tens_char  = (blank_leading && (tens == 4'd0)) ? ASCII_SPACE
                                                       : ASCII_ZERO + {3'b000, tens};
        units_char = ASCII_ZERO + {3'b000, units};
        pack_score = {tens_char, units_char};
    endfunction

endpackage

// File: rtl/score_ascii_encoder_bcd_add3.sv
// Double-dabble nibble correction: digits of 5 or more get +3 before the shift.
// Purely combinational, no handshake.
module bcd_add3 (
    input  logic [3:0] in_i,
    output logic [3:0] out_o
);

    always_comb begin
        out_o = in_i;
        if (in_i >= 4'd5) begin
            out_o = in_i + 4'd3;
        end
    end

endmodule

// File: rtl/score_ascii_encoder.sv
// Iterative binary-to-two-digit-ASCII converter; SCORE_W+1 cycles after the load edge.
// No backpressure: input changes during a conversion are picked up afterwards.
module score_ascii_encoder
    import score_ascii_encoder_pkg::*;
#(
    parameter int SCORE_W       = 7,
    parameter int SCORE_MAX     = 99,
    parameter bit BLANK_LEADING = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SCORE_W-1:0]      score_in,
    output logic [SCORE_WORD_W-1:0] score_out,
    output logic                    busy,
    output logic                    done
);

    localparam int SR_W  = BCD_W + SCORE_W;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    localparam logic [SCORE_W-1:0]      MAX_V      = SCORE_W'(SCORE_MAX);
    localparam logic [CNT_W-1:0]        LAST_SHIFT = CNT_W'(SCORE_W - 1);
    localparam logic [SCORE_WORD_W-1:0] RESET_WORD = pack_score(4'd0, 4'd0, BLANK_LEADING);

    state_e                    state_q, state_d;
    logic [SCORE_W-1:0]        last_q, last_d;
    logic [SR_W-1:0]           sr_q, sr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SCORE_WORD_W-1:0]   out_q, out_d;
    logic                      done_q, done_d;

    logic [SCORE_W-1:0]        sat_score;
    logic [3:0]                tens_adj;
    logic [3:0]                units_adj;
    logic [SR_W-1:0]           sr_corrected;

    assign sat_score = (score_in > MAX_V) ? MAX_V : score_in;

    bcd_add3 u_add3_tens (
        .in_i  (sr_q[SR_W-1 -: 4]),
        .out_o (tens_adj)
    );

    bcd_add3 u_add3_units (
        .in_i  (sr_q[SR_W-5 -: 4]),
        .out_o (units_adj)
    );

    assign sr_corrected = {tens_adj, units_adj, sr_q[SCORE_W-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            out_q   <= RESET_WORD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (score_in != last_q) begin
                    // last_d keeps the raw value so a clamped input still settles.
                    last_d  = score_in;
                    sr_d    = {{BCD_W{1'b0}}, sat_score};
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_corrected << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_d   = pack_score(sr_q[SR_W-1 -: 4], sr_q[SR_W-5 -: 4], BLANK_LEADING);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign score_out = out_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_score_ascii_encoder.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor pops on each done.
// Covers reset values, latency, saturation, mid-conversion change, blanking and abort.
module tb_score_ascii_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  score_in0, score_in1;
    logic [13:0] score_out0, score_out1;
    logic        busy0, busy1, done0, done1;

    logic [13:0] exp_q0[$];
    logic [13:0] exp_q1[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          done_cnt0  = 0;
    int          done_cnt1  = 0;
    int          base_cnt;

    always #5 clk = ~clk;

    score_ascii_encoder #(.SCORE_W(7), .SCORE_MAX(99), .BLANK_LEADING(1'b0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .score_in  (score_in0),
        .score_out (score_out0),
        .busy      (busy0),
        .done      (done0)
    );

    score_ascii_encoder #(.SCORE_W(7), .SCORE_MAX(99), .BLANK_LEADING(1'b1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .score_in  (score_in1),
        .score_out (score_out1),
        .busy      (busy1),
        .done      (done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done0) begin
                done_cnt0++;
                if (exp_q0.size() == 0) begin
                    check("unexpected_done0", 32'(score_out0), 32'hFFFF_FFFF);
                end else begin
                    check("score_out0", 32'(score_out0), 32'(exp_q0.pop_front()));
                    check("busy0_at_done", 32'(busy0), 32'd0);
                end
            end
            if (done1) begin
                done_cnt1++;
                if (exp_q1.size() == 0) begin
                    check("unexpected_done1", 32'(score_out1), 32'hFFFF_FFFF);
                end else begin
                    check("score_out1", 32'(score_out1), 32'(exp_q1.pop_front()));
                    check("busy1_at_done", 32'(busy1), 32'd0);
                end
            end
        end
    end

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            check("drain_timeout_pending", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
            exp_q0.delete();
            exp_q1.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        score_in0 = 7'd0;
        score_in1 = 7'd0;
        #1;
        check("reset_score_out0", 32'(score_out0), 32'h1830);
        check("reset_busy0", 32'(busy0), 32'd0);
        check("reset_done0", 32'(done0), 32'd0);
        check("reset_score_out1", 32'(score_out1), 32'h1030);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Held zero must never start a conversion.
        repeat (20) @(posedge clk);
        #1;
        check("idle_no_done", 32'(done_cnt0 + done_cnt1), 32'd0);
        check("idle_busy0", 32'(busy0), 32'd0);

        // Latency and atomic update for 42.
        exp_q0.push_back(14'h1A32);
        base_cnt  = done_cnt0;
        score_in0 = 7'd42;
        @(posedge clk);                       // edge E: load
        @(negedge clk);
        check("busy0_after_load", 32'(busy0), 32'd1);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);                   // after edges E+1 .. E+7
            check("no_early_done", 32'(done0), 32'd0);
            if (i == 4) check("no_partial_out", 32'(score_out0), 32'h1830);
        end
        @(negedge clk);                       // after edge E+8
        check("done_at_E8", 32'(done0), 32'd1);
        @(negedge clk);
        check("done_single_cycle", 32'(done0), 32'd0);
        check("busy0_low_after", 32'(busy0), 32'd0);
        drain(50);
        check("one_done_42", 32'(done_cnt0 - base_cnt), 32'd1);

        // Saturation.
        exp_q0.push_back(14'h1CB9);
        score_in0 = 7'd127;
        drain(50);
        exp_q0.push_back(14'h1CB9);
        score_in0 = 7'd100;
        drain(50);

        // Change during conversion is picked up afterwards.
        base_cnt = done_cnt0;
        exp_q0.push_back(14'h1835);
        exp_q0.push_back(14'h1837);
        score_in0 = 7'd5;
        repeat (3) @(posedge clk);
        #1 score_in0 = 7'd7;
        drain(80);
        check("two_dones_5_7", 32'(done_cnt0 - base_cnt), 32'd2);

        // Leading-blank instance.
        exp_q1.push_back(14'h1037);
        score_in1 = 7'd7;
        drain(50);
        exp_q1.push_back(14'h18B0);
        score_in1 = 7'd10;
        drain(50);

        // Abort a conversion with reset.
        base_cnt  = done_cnt0;
        score_in0 = 7'd42;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_score_out0", 32'(score_out0), 32'h1830);
        check("abort_busy0", 32'(busy0), 32'd0);
        check("abort_done0", 32'(done0), 32'd0);
        check("abort_score_out1", 32'(score_out1), 32'h1030);
        repeat (2) @(posedge clk);
        check("abort_no_done", 32'(done_cnt0 - base_cnt), 32'd0);
        // last value clears on reset, so both held inputs reconvert.
        exp_q0.push_back(14'h1A32);
        exp_q1.push_back(14'h18B0);
        #1 rst = 1'b0;
        drain(50);
        check("reconvert_count", 32'(done_cnt0 - base_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
